lsu_mem_master: RTL and testbench

LSU_MEM_MASTER -- requirements
Module: lsu_mem_master

---
 rtl/lsu_mem_master.sv | 186 ++++++++++++++++++
 tb/tb_lsu_mem_master.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: single-outstanding load/store unit bus master.
// Accepts one RV32 load/store at a time, drives a word-addressed memory
// with byte write enables and formats load data by size/sign.
// Optional feature macro: MISALIGN_CHECK_EN. When it is defined, misaligned
// H/W accesses are rejected. When it is undefined, they are silently aligned.
module lsu_mem_master (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_misaligned,
  output logic [31:0] mem_addr,
  output logic        mem_ren,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_mis_q;

  logic        accept;
  logic        misaligned;
  logic [1:0]  eff_off;

  // funct3[1:0]: 00 byte, 01 half, anything else (incl. reserved codes) word.
  // funct3[2] selects zero-extension for loads.
  function automatic logic is_byte(input logic [2:0] f3);
    return (f3[1:0] == 2'b00);
  endfunction

  function automatic logic is_half(input logic [2:0] f3);
    return (f3[1:0] == 2'b01);
  endfunction

  // Byte enables for a store of the given size at the given byte lane.
  function automatic logic [3:0] store_mask(input logic [2:0] f3,
                                            input logic [1:0] off);
    logic [3:0] m;
    m = 4'b1111;
    if (is_byte(f3))
      m = 4'b0001 << off;
    else if (is_half(f3))
      m = 4'b0011 << off;
    return m;
  endfunction

  // Store data replicated across all lanes so the mask alone picks the bytes.
  function automatic logic [31:0] store_data(input logic [2:0]  f3,
                                             input logic [31:0] wd);
    logic [31:0] d;
    d = wd;
    if (is_byte(f3))
      d = {4{wd[7:0]}};
    else if (is_half(f3))
      d = {2{wd[15:0]}};
    return d;
  endfunction

  // Shift the addressed lane down to bit 0, then mask or sign-extend.
  function automatic logic [31:0] load_format(input logic [2:0]  f3,
                                              input logic [1:0]  off,
                                              input logic [31:0] rd);
    logic [31:0] s;
    logic [31:0] r;
    logic [4:0]  shamt;
    shamt = {off, 3'b000};
    s     = rd >> shamt;
    r     = rd;
    if (is_byte(f3))
      r = f3[2] ? {24'd0, s[7:0]} : {{24{s[7]}}, s[7:0]};
    else if (is_half(f3))
      r = f3[2] ? {16'd0, s[15:0]} : {{16{s[15]}}, s[15:0]};
    return r;
  endfunction

`ifdef MISALIGN_CHECK_EN
  // Accesses that pass the check are naturally aligned, so the raw offset is usable.
  assign misaligned = (is_half(req_funct3) && req_addr[0]) ||
                      (!is_byte(req_funct3) && !is_half(req_funct3) &&
                       (req_addr[1:0] != 2'b00));
  assign eff_off    = req_addr[1:0];
`else
  // Without the check, the low offset bits below the access size are dropped.
  assign misaligned = 1'b0;
  assign eff_off    = is_byte(req_funct3) ? req_addr[1:0] :
                      is_half(req_funct3) ? {req_addr[1], 1'b0} :
                                            2'b00;
`endif

  assign accept = req_valid && req_ready;

  // State register; reset drops any operation in flight.
  always_ff @(posedge clk) begin
    if (reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Next-state and bus strobes; strobes are live only in ISSUE.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_ren   = 1'b0;
    mem_wmask = 4'b0000;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid)
          state_d = misaligned ? DONE : ISSUE;
      end
      ISSUE: begin
        if (we_q) begin
          mem_wmask = store_mask(funct3_q, off_q);
          state_d   = DONE;
        end else begin
          mem_ren = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        state_d = DONE;
      end
      DONE: begin
        rsp_valid = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Request latch, bus address/data, and response data registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      off_q       <= 2'b00;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      rsp_rdata_q <= 32'd0;
      rsp_mis_q   <= 1'b0;
    end else if (accept) begin
      we_q        <= req_we;
      funct3_q    <= req_funct3;
      off_q       <= eff_off;
      rsp_rdata_q <= 32'd0;
      rsp_mis_q   <= misaligned;
      if (!misaligned) begin
        mem_addr_q <= {req_addr[31:2], 2'b00};
        if (req_we)
          mem_wdata_q <= store_data(req_funct3, req_wdata);
      end
    end else if (state_q == WAIT) begin
      rsp_rdata_q <= load_format(funct3_q, off_q, mem_rdata);
    end
  end

  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_misaligned = rsp_mis_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// tb_lsu_mem_master: directed bench for lsu_mem_master with a small
// registered-read memory model and hand-computed expected values.
module tb_lsu_mem_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_misaligned;
  logic [31:0] mem_addr;
  logic        mem_ren;
  logic [31:0] mem_rdata;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;

  int vectors = 0;
  int errors  = 0;

  lsu_mem_master dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .rsp_misaligned (rsp_misaligned),
    .mem_addr       (mem_addr),
    .mem_ren        (mem_ren),
    .mem_rdata      (mem_rdata),
    .mem_wdata      (mem_wdata),
    .mem_wmask      (mem_wmask)
  );

  always #5 clk = ~clk;

  // Memory model: registered read, byte-masked write on the same edge.
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (reset) begin
      mem[100]  <= 32'h04030201;  // 0x190
      mem[103]  <= 32'hFF0F0E0D;  // 0x19C
      mem[104]  <= 32'h00000000;  // 0x1A0
      mem_rdata <= 32'd0;
    end else begin
      if (mem_ren)
        mem_rdata <= mem[mem_addr[9:2]];
      for (int b = 0; b < 4; b++)
        if (mem_wmask[b])
          mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single edge; returns in the cycle after acceptance.
  task automatic issue(input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    req_valid  = 1'b1;
    chk("req_ready_before", {31'd0, req_ready}, 32'd1);
    step();
    req_valid  = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] waddr, input logic [31:0] exp);
    issue(1'b0, f3, a, 32'd0);
    chk({tag, "_ren_t1"},   {31'd0, mem_ren}, 32'd1);
    chk({tag, "_addr_t1"},  mem_addr, waddr);
    chk({tag, "_wmask_t1"}, {28'd0, mem_wmask}, 32'd0);
    step();
    chk({tag, "_ren_t2"},   {31'd0, mem_ren}, 32'd0);
    chk({tag, "_vld_t2"},   {31'd0, rsp_valid}, 32'd0);
    step();
    chk({tag, "_vld_t3"},   {31'd0, rsp_valid}, 32'd1);
    chk({tag, "_data_t3"},  rsp_rdata, exp);
    chk({tag, "_mis_t3"},   {31'd0, rsp_misaligned}, 32'd0);
    step();
    chk({tag, "_vld_t4"},   {31'd0, rsp_valid}, 32'd0);
  endtask

  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] emask,
                          input logic [31:0] edata);
    issue(1'b1, f3, a, wd);
    chk({tag, "_wmask_t1"}, {28'd0, mem_wmask}, {28'd0, emask});
    chk({tag, "_wdata_t1"}, mem_wdata, edata);
    chk({tag, "_addr_t1"},  mem_addr, {a[31:2], 2'b00});
    chk({tag, "_ren_t1"},   {31'd0, mem_ren}, 32'd0);
    step();
    chk({tag, "_vld_t2"},   {31'd0, rsp_valid}, 32'd1);
    chk({tag, "_rdata_t2"}, rsp_rdata, 32'd0);
    chk({tag, "_wmask_t2"}, {28'd0, mem_wmask}, 32'd0);
    step();
    chk({tag, "_vld_t3"},   {31'd0, rsp_valid}, 32'd0);
  endtask

  task automatic do_misload(input string tag, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] exp_aligned);
`ifdef MISALIGN_CHECK_EN
    issue(1'b0, f3, a, 32'd0);
    chk({tag, "_vld_t1"},   {31'd0, rsp_valid}, 32'd1);
    chk({tag, "_mis_t1"},   {31'd0, rsp_misaligned}, 32'd1);
    chk({tag, "_rdata_t1"}, rsp_rdata, 32'd0);
    chk({tag, "_ren_t1"},   {31'd0, mem_ren}, 32'd0);
    chk({tag, "_wmask_t1"}, {28'd0, mem_wmask}, 32'd0);
    step();
    chk({tag, "_vld_t2"},   {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_ren_t2"},   {31'd0, mem_ren}, 32'd0);
    chk({tag, "_ready_t2"}, {31'd0, req_ready}, 32'd1);
`else
    do_load(tag, f3, a, {a[31:2], 2'b00}, exp_aligned);
`endif
  endtask

  int n_rsp, n_ren, n_rdy;

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    step();
    step();
    chk("rst_ready",  {31'd0, req_ready}, 32'd1);
    chk("rst_rspv",   {31'd0, rsp_valid}, 32'd0);
    chk("rst_rdata",  rsp_rdata, 32'd0);
    chk("rst_mis",    {31'd0, rsp_misaligned}, 32'd0);
    chk("rst_ren",    {31'd0, mem_ren}, 32'd0);
    chk("rst_wmask",  {28'd0, mem_wmask}, 32'd0);
    chk("rst_maddr",  mem_addr, 32'd0);
    chk("rst_mwdata", mem_wdata, 32'd0);
    reset = 1'b0;
    step();

    // Loads of every size and sign against the preloaded words.
    do_load("lb193",  3'b000, 32'h193, 32'h190, 32'h00000004);
    do_load("lb19f",  3'b000, 32'h19F, 32'h19C, 32'hFFFFFFFF);
    do_load("lbu19f", 3'b100, 32'h19F, 32'h19C, 32'h000000FF);
    do_load("lh19e",  3'b001, 32'h19E, 32'h19C, 32'hFFFFFF0F);
    do_load("lhu19e", 3'b101, 32'h19E, 32'h19C, 32'h0000FF0F);

    // Stores followed by read-back of the merged word.
    do_store("sb191", 3'b000, 32'h191, 32'h000000AB, 4'b0010, 32'hABABABAB);
    do_load("lw190",  3'b010, 32'h190, 32'h190, 32'h0403AB01);
    do_store("sh19e", 3'b001, 32'h19E, 32'h0000BEEF, 4'b1100, 32'hBEEFBEEF);
    do_load("lh19c",  3'b001, 32'h19C, 32'h19C, 32'h00000E0D);
    do_load("lw19c",  3'b010, 32'h19C, 32'h19C, 32'hBEEF0E0D);
    do_store("sw1a0", 3'b010, 32'h1A0, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D);
    do_load("lb1a1",  3'b000, 32'h1A1, 32'h1A0, 32'hFFFFFFF0);
    do_load("lhu1a2", 3'b101, 32'h1A2, 32'h1A0, 32'h0000CAFE);

    // Reserved funct3 codes behave as word accesses.
    do_load("rsv111", 3'b111, 32'h1A0, 32'h1A0, 32'hCAFEF00D);
    do_store("rsv011", 3'b011, 32'h1A0, 32'h12345678, 4'b1111, 32'h12345678);
    do_load("rsv110", 3'b110, 32'h1A0, 32'h1A0, 32'h12345678);

    // Misaligned accesses: rejected with the check, aligned down without it.
    do_misload("lw192", 3'b010, 32'h192, 32'h0403AB01);
    do_misload("lh193", 3'b001, 32'h193, 32'h00000403);

    // Reset while a load waits for data: dropped without a response.
    issue(1'b0, 3'b010, 32'h190, 32'd0);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rstw_ready", {31'd0, req_ready}, 32'd1);
    chk("rstw_vld",   {31'd0, rsp_valid}, 32'd0);
    n_rsp = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (rsp_valid) n_rsp++;
    end
    chk("rstw_norsp", n_rsp, 32'd0);

    // req_valid held high: one complete access per DONE, none lost or duplicated.
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h190;
    req_valid  = 1'b1;
    n_rsp = 0;
    n_ren = 0;
    n_rdy = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (rsp_valid) begin
        n_rsp++;
        chk("hold_data", rsp_rdata, 32'h04030201);
      end
      if (mem_ren) n_ren++;
      if (req_ready) n_rdy++;
    end
    req_valid = 1'b0;
    chk("hold_rsp", n_rsp, 32'd4);
    chk("hold_ren", n_ren, 32'd4);
    chk("hold_rdy", n_rdy, 32'd4);
    step();
    chk("hold_after_ren", {31'd0, mem_ren}, 32'd0);
    chk("hold_after_rdy", {31'd0, req_ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
